player_hit_ctl: RTL and testbench
=================================

// Module: player_hit_ctl
// PURPOSE
//  Receiving end of the enemy-missile path: takes enemy missile position and valid flag
//  (from ctl_missile_en) and the player position, and decides once per frame whether
//  the player was hit. Owns the player lives counter, the post-hit invulnerability
//  window with sprite blinking, and game-over. Pulses missile_clr so the missile
//  controller retires the missile that scored. Sits beside the player ctl/draw blocks
//  on the pclk domain.
// PARAMETERS
//  LIVES        3    lives loaded at reset/restart (1..7)
//  PLAYER_W     64   player hitbox width, pixels
//  PLAYER_H     48   player hitbox height, pixels
//  MIS_W        4    missile hitbox width, pixels
//  MIS_H        12   missile hitbox height, pixels
//  INVUL_FRAMES 120  frames of invulnerability after a non-fatal hit (1..255)
//  BLINK_FRAMES 8    frames per player_visible toggle during invulnerability (power of 2)
// PORTS
//  pclk            in   1   pixel clock, all logic on rising edge
//  rst             in   1   asynchronous reset, active high
//  vsync_in        in   1   vertical sync from timing chain; rising edge = frame tick
//  xpos_player     in   11  player hitbox left x
//  ypos_player     in   11  player hitbox top y
//  xpos_missile    in   11  enemy missile left x
//  ypos_missile    in   11  enemy missile top y
//  on_missile      in   1   enemy missile in flight
//  restart         in   1   level-sensitive new-game request
//  hit             out  1   one-cycle pulse: player hit this frame
//  missile_clr     out  1   one-cycle pulse, coincident with hit
//  lives           out  3   remaining lives
//  player_visible  out  1   draw-enable for the player sprite
//  game_over       out  1   high while in DEAD
// BEHAVIOUR
//  Reset (async): state=ALIVE, lives=LIVES, hit=0, missile_clr=0, player_visible=1,
//   game_over=0, vsync_q=0, invul_cnt=0, blink_cnt=0. All outputs registered.
//  Frame tick: vsync_q <= vsync_in each cycle; tick = vsync_in & ~vsync_q, 1 cycle wide.
//  Overlap (combinational, operands zero-extended to 12 bit, no wrap):
//   xm < xp+PLAYER_W && xm+MIS_W > xp && ym < yp+PLAYER_H && ym+MIS_H > yp.
//   Edge-touching (xm+MIS_W == xp) is NOT an overlap.
//  FSM states ALIVE, HIT, INVUL, DEAD:
//   ALIVE: on tick & on_missile & overlap -> HIT. Otherwise stay. player_visible=1.
//   HIT (exactly 1 cycle): hit=1, missile_clr=1, lives<=lives-1.
//    If lives==1 on entry -> DEAD, else -> INVUL with invul_cnt=INVUL_FRAMES, blink_cnt=0.
//   INVUL: on each tick invul_cnt--, blink_cnt++; player_visible toggles each time
//    blink_cnt wraps mod BLINK_FRAMES, starting at 0 (hidden) on INVUL entry. Collisions
//    ignored. When invul_cnt reaches 0 on a tick -> ALIVE, player_visible=1 next cycle.
//   DEAD: game_over=1, player_visible=0, lives=0; ignores missile. Stays until restart.
//  restart: highest priority after rst, any state: next cycle state=ALIVE, lives=LIVES,
//   counters 0, player_visible=1, game_over=0, hit/missile_clr=0. No hit can register
//   on the cycle restart is high.
//  Latency: vsync_in rises in cycle n -> tick in cycle n -> hit/missile_clr high in n+1.
//  At most one hit per frame; a missile that stays overlapping after missile_clr
//   cannot hit again (INVUL or DEAD absorbs it).
//  lives never underflows; never exceeds LIVES.
//  on_missile low at the tick -> no hit even if coordinates overlap.
//  Reset asserted mid-INVUL or mid-HIT: outputs return to reset values immediately.
// TESTING
//  1 Player (300,500), missile (320,510) on=1, vsync rise -> hit & missile_clr 1 cycle
//    later, lives 3->2, player_visible 0 next cycle.
//  2 Missile (364,510) (touching right edge, PLAYER_W=64) on=1 -> no hit, lives=3.
//  3 After hit, keep overlap 120 frames -> no further hit; visible toggles every 8 frames;
//    after tick 120 state ALIVE, visible=1; next overlapping tick -> hit, lives 2->1.
//  4 Three hits from LIVES=3 -> lives=0, game_over=1, visible=0; further overlaps ignored;
//    restart pulse -> lives=3, game_over=0, visible=1 next cycle.
//  5 Overlap with on_missile=0 at tick -> no hit; overlap between ticks only -> no hit.
//  6 Assert rst during INVUL (invul_cnt=50) -> immediate ALIVE, lives=3, visible=1.

Source files
------------

// File: rtl/player_hit_ctl.sv
// Enemy-missile hit detection for the player: lives, post-hit invulnerability
// with sprite blinking, and game-over. One collision decision per frame tick.
module player_hit_ctl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned PLAYER_W     = 64,
  parameter int unsigned PLAYER_H     = 48,
  parameter int unsigned MIS_W        = 4,
  parameter int unsigned MIS_H        = 12,
  parameter int unsigned INVUL_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [10:0] xpos_player,
  input  logic [10:0] ypos_player,
  input  logic [10:0] xpos_missile,
  input  logic [10:0] ypos_missile,
  input  logic        on_missile,
  input  logic        restart,
  output logic        hit,
  output logic        missile_clr,
  output logic [2:0]  lives,
  output logic        player_visible,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    INVUL = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  INVUL_INIT = 8'(INVUL_FRAMES);
  localparam logic [7:0]  BLINK_MASK = 8'(BLINK_FRAMES - 1);
  localparam logic [11:0] PW = 12'(PLAYER_W);
  localparam logic [11:0] PH = 12'(PLAYER_H);
  localparam logic [11:0] MW = 12'(MIS_W);
  localparam logic [11:0] MH = 12'(MIS_H);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic       missile_clr_q, missile_clr_d;
  logic       player_visible_q, player_visible_d;
  logic       game_over_q, game_over_d;
  logic       vsync_q, vsync_d;
  logic [7:0] invul_cnt_q, invul_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;

  logic        tick;
  logic        overlap;
  logic [11:0] xp, yp, xm, ym;
  logic [7:0]  blink_nxt;

  assign tick = vsync_in & ~vsync_q;

  // Zero-extend to 12 bits so the far edges cannot wrap; strict compares
  // make edge-touching boxes non-overlapping.
  assign xp = {1'b0, xpos_player};
  assign yp = {1'b0, ypos_player};
  assign xm = {1'b0, xpos_missile};
  assign ym = {1'b0, ypos_missile};
  assign overlap = (xm < xp + PW) && (xm + MW > xp) &&
                   (ym < yp + PH) && (ym + MH > yp);

  assign blink_nxt = blink_cnt_q + 8'd1;

  always_comb begin
    state_d          = state_q;
    lives_d          = lives_q;
    hit_d            = 1'b0;
    missile_clr_d    = 1'b0;
    player_visible_d = player_visible_q;
    game_over_d      = game_over_q;
    vsync_d          = vsync_in;
    invul_cnt_d      = invul_cnt_q;
    blink_cnt_d      = blink_cnt_q;

    unique case (state_q)
      ALIVE: begin
        player_visible_d = 1'b1;
        if (tick && on_missile && overlap) begin
          state_d       = HIT;
          hit_d         = 1'b1;
          missile_clr_d = 1'b1;
        end
      end
      HIT: begin
        if (lives_q <= 3'd1) begin
          state_d          = DEAD;
          lives_d          = '0;
          game_over_d      = 1'b1;
          player_visible_d = 1'b0;
        end else begin
          state_d          = INVUL;
          lives_d          = lives_q - 3'd1;
          invul_cnt_d      = INVUL_INIT;
          blink_cnt_d      = '0;
          player_visible_d = 1'b0;
        end
      end
      INVUL: begin
        if (tick) begin
          invul_cnt_d = invul_cnt_q - 8'd1;
          blink_cnt_d = blink_nxt;
          if ((blink_nxt & BLINK_MASK) == '0)
            player_visible_d = ~player_visible_q;
          if (invul_cnt_q <= 8'd1) begin
            state_d          = ALIVE;
            invul_cnt_d      = '0;
            blink_cnt_d      = '0;
            player_visible_d = 1'b1;
          end
        end
      end
      DEAD: begin
        lives_d          = '0;
        game_over_d      = 1'b1;
        player_visible_d = 1'b0;
      end
      default: state_d = ALIVE;
    endcase

    if (restart) begin
      state_d          = ALIVE;
      lives_d          = LIVES_INIT;
      hit_d            = 1'b0;
      missile_clr_d    = 1'b0;
      player_visible_d = 1'b1;
      game_over_d      = 1'b0;
      invul_cnt_d      = '0;
      blink_cnt_d      = '0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q          <= ALIVE;
      lives_q          <= LIVES_INIT;
      hit_q            <= 1'b0;
      missile_clr_q    <= 1'b0;
      player_visible_q <= 1'b1;
      game_over_q      <= 1'b0;
      vsync_q          <= 1'b0;
      invul_cnt_q      <= '0;
      blink_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      lives_q          <= lives_d;
      hit_q            <= hit_d;
      missile_clr_q    <= missile_clr_d;
      player_visible_q <= player_visible_d;
      game_over_q      <= game_over_d;
      vsync_q          <= vsync_d;
      invul_cnt_q      <= invul_cnt_d;
      blink_cnt_q      <= blink_cnt_d;
    end
  end

  assign hit            = hit_q;
  assign missile_clr    = missile_clr_q;
  assign lives          = lives_q;
  assign player_visible = player_visible_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_player_hit_ctl.sv
// Directed bench for player_hit_ctl with hand-computed expectations.
module tb_player_hit_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic [10:0] xpos_player = 11'd300;
  logic [10:0] ypos_player = 11'd500;
  logic [10:0] xpos_missile = 11'd0;
  logic [10:0] ypos_missile = 11'd0;
  logic        on_missile = 1'b0;
  logic        restart = 1'b0;
  logic        hit, missile_clr, player_visible, game_over;
  logic [2:0]  lives;

  int total = 0;
  int bad = 0;

  player_hit_ctl #(
    .LIVES(3), .PLAYER_W(64), .PLAYER_H(48), .MIS_W(4), .MIS_H(12),
    .INVUL_FRAMES(120), .BLINK_FRAMES(8)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
    .xpos_player(xpos_player), .ypos_player(ypos_player),
    .xpos_missile(xpos_missile), .ypos_missile(ypos_missile),
    .on_missile(on_missile), .restart(restart),
    .hit(hit), .missile_clr(missile_clr), .lives(lives),
    .player_visible(player_visible), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise vsync for one cycle; returns at the negedge right after the tick edge.
  task automatic do_tick();
    vsync_in = 1'b1;
    @(negedge pclk);
    vsync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  task automatic set_missile(input int x, input int y, input logic on);
    xpos_missile = 11'(x);
    ypos_missile = 11'(y);
    on_missile   = on;
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_lives", 32'(lives), 3);
    check("rst_visible", 32'(player_visible), 1);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_clr", 32'(missile_clr), 0);

    // Touching right edge: 364 == 300+64
    set_missile(364, 510, 1'b1);
    do_tick();
    check("edge_right_hit", 32'(hit), 0);
    idle(2);
    check("edge_right_lives", 32'(lives), 3);
    // Touching top edge: 488+12 == 500
    set_missile(320, 488, 1'b1);
    do_tick();
    check("edge_top_hit", 32'(hit), 0);
    idle(2);
    // Touching left edge: 296+4 == 300
    set_missile(296, 510, 1'b1);
    do_tick();
    check("edge_left_hit", 32'(hit), 0);
    idle(2);

    // Overlap but missile not in flight
    set_missile(320, 510, 1'b0);
    do_tick();
    check("off_missile_hit", 32'(hit), 0);
    idle(2);
    check("off_missile_lives", 32'(lives), 3);
    // Overlap between ticks only
    set_missile(320, 510, 1'b1);
    idle(3);
    check("no_tick_hit", 32'(hit), 0);
    set_missile(100, 100, 1'b1);
    do_tick();
    check("moved_away_hit", 32'(hit), 0);
    idle(2);

    // First hit
    set_missile(320, 510, 1'b1);
    do_tick();
    check("hit1_hit", 32'(hit), 1);
    check("hit1_clr", 32'(missile_clr), 1);
    idle(1);
    check("hit1_pulse_end", 32'(hit), 0);
    check("hit1_clr_end", 32'(missile_clr), 0);
    check("hit1_lives", 32'(lives), 2);
    check("hit1_visible", 32'(player_visible), 0);
    idle(2);

    // Invulnerability with overlap held for 120 frames
    for (int k = 1; k <= 120; k++) begin
      do_tick();
      check("invul_hit", 32'(hit), 0);
      if (k < 120) check("invul_visible", 32'(player_visible), 32'((k / 8) % 2));
      else         check("invul_end_visible", 32'(player_visible), 1);
      idle(2);
    end
    check("invul_lives", 32'(lives), 2);

    // Second hit right after invulnerability ends
    do_tick();
    check("hit2_hit", 32'(hit), 1);
    idle(1);
    check("hit2_lives", 32'(lives), 1);
    idle(1);
    for (int k = 1; k <= 120; k++) begin
      do_tick();
      idle(1);
    end

    // Third hit is fatal
    do_tick();
    check("hit3_hit", 32'(hit), 1);
    check("hit3_clr", 32'(missile_clr), 1);
    idle(1);
    check("dead_lives", 32'(lives), 0);
    check("dead_game_over", 32'(game_over), 1);
    check("dead_visible", 32'(player_visible), 0);
    idle(1);
    do_tick();
    check("dead_ignore_hit", 32'(hit), 0);
    idle(2);
    check("dead_ignore_lives", 32'(lives), 0);

    restart = 1'b1;
    @(negedge pclk);
    restart = 1'b0;
    check("restart_lives", 32'(lives), 3);
    check("restart_game_over", 32'(game_over), 0);
    check("restart_visible", 32'(player_visible), 1);
    idle(2);

    // Tick coincident with restart must not score
    restart = 1'b1;
    do_tick();
    restart = 1'b0;
    check("restart_tick_hit", 32'(hit), 0);
    check("restart_tick_clr", 32'(missile_clr), 0);
    idle(2);
    check("restart_tick_lives", 32'(lives), 3);

    // Async reset in INVUL with invul_cnt at 50
    do_tick();
    check("hit4_hit", 32'(hit), 1);
    idle(2);
    for (int k = 1; k <= 70; k++) begin
      do_tick();
      idle(1);
    end
    check("pre_rst_lives", 32'(lives), 2);
    check("pre_rst_visible", 32'(player_visible), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_lives", 32'(lives), 3);
    check("async_rst_visible", 32'(player_visible), 1);
    check("async_rst_hit", 32'(hit), 0);
    @(negedge pclk);
    rst = 1'b0;
    idle(1);
    // Back in ALIVE: an overlapping tick scores again
    do_tick();
    check("post_rst_hit", 32'(hit), 1);
    idle(1);
    check("post_rst_lives", 32'(lives), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
